// File: rtl/sar_scan_sequencer.sv
// Sequences an 8-bit SAR core across an NCH-way analog mux: settle, average 2^AVG_LOG2 samples, report one result per channel.
// Results are single-cycle pulses with no backpressure; a conversion without SarReady inside TIMEOUT cycles drops that channel.
module sar_scan_sequencer #(
    parameter int NCH      = 4,
    parameter int AVG_LOG2 = 2,
    parameter int SETTLE   = 2,
    parameter int TIMEOUT  = 31
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_scan_en,
    input  logic                     i_continuous,
    input  logic [NCH-1:0]           i_chan_mask,
    input  logic                     i_err_clr,
    input  logic                     i_sar_ready,
    input  logic [7:0]               i_sar_data,
    output logic                     o_sar_reset,
    output logic [$clog2(NCH)-1:0]   o_chan_sel,
    output logic                     o_busy,
    output logic                     o_result_valid,
    output logic [$clog2(NCH)-1:0]   o_result_chan,
    output logic [7:0]               o_result_data,
    output logic                     o_timeout_err
);

    localparam int CW = $clog2(NCH);
    localparam int AW = 8 + AVG_LOG2;
    localparam int SW = AVG_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] NSAMP = SW'(1 << AVG_LOG2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CONV,
        S_REARM,
        S_DONE,
        S_NEXT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NCH-1:0]  r_scan_mask;
    logic [CW-1:0]   r_chan_sel;
    logic [3:0]      r_settle_cnt;
    logic [TW-1:0]   r_tmo_cnt;
    logic [SW-1:0]   r_samp_cnt;
    logic [AW-1:0]   r_acc;
    logic            r_sar_reset;
    logic            r_busy;
    logic            r_result_valid;
    logic [CW-1:0]   r_result_chan;
    logic [7:0]      r_result_data;
    logic            r_timeout_err;

    logic [NCH-1:0]  w_above;
    logic            w_mask_ld;
    logic            w_chan_ld;
    logic [CW-1:0]   w_chan_val;
    logic            w_sample;
    logic            w_timeout;
    logic            w_settle_entry;
    logic [AW-1:0]   w_acc_sum;
    logic [SW-1:0]   w_samp_inc;

    function automatic logic [CW-1:0] f_lowest(input logic [NCH-1:0] m);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) idx = CW'(i);
        end
        return idx;
    endfunction

    assign w_acc_sum      = r_acc + AW'(i_sar_data);
    assign w_samp_inc     = r_samp_cnt + SW'(1);
    assign w_settle_entry = (w_state_nxt == S_SETTLE) && (r_state != S_SETTLE);

    // Enabled channels strictly above the one currently selected.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_above[i] = r_scan_mask[i] && (CW'(i) > r_chan_sel);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_ld   = 1'b0;
        w_chan_ld   = 1'b0;
        w_chan_val  = r_chan_sel;
        w_sample    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_scan_en && (|i_chan_mask)) begin
                    w_mask_ld   = 1'b1;
                    w_chan_ld   = 1'b1;
                    w_chan_val  = f_lowest(i_chan_mask);
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == 4'(SETTLE - 1)) w_state_nxt = S_CONV;
            end
            S_CONV: begin
                if (i_sar_ready) begin
                    w_sample    = 1'b1;
                    w_state_nxt = (w_samp_inc == NSAMP) ? S_DONE : S_REARM;
                end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_NEXT;
                end
            end
            S_REARM: w_state_nxt = S_CONV;
            S_DONE:  w_state_nxt = S_NEXT;
            S_NEXT: begin
                // Dropping ScanEn lets the current channel finish, then stops here.
                if (!i_scan_en) begin
                    w_state_nxt = S_IDLE;
                end else if (|w_above) begin
                    w_chan_ld   = 1'b1;
                    w_chan_val  = f_lowest(w_above);
                    w_state_nxt = S_SETTLE;
                end else if (i_continuous && (|i_chan_mask)) begin
                    w_mask_ld   = 1'b1;
                    w_chan_ld   = 1'b1;
                    w_chan_val  = f_lowest(i_chan_mask);
                    w_state_nxt = S_SETTLE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scan_mask    <= '0;
            r_chan_sel     <= '0;
            r_settle_cnt   <= '0;
            r_tmo_cnt      <= '0;
            r_samp_cnt     <= '0;
            r_acc          <= '0;
            r_sar_reset    <= 1'b1;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_chan  <= '0;
            r_result_data  <= '0;
            r_timeout_err  <= 1'b0;
        end else begin
            if (w_mask_ld) r_scan_mask <= i_chan_mask;
            if (w_chan_ld) r_chan_sel  <= w_chan_val;
            r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + 4'd1 : 4'd0;
            r_tmo_cnt    <= (r_state == S_CONV && !i_sar_ready) ? r_tmo_cnt + TW'(1) : '0;
            if (w_settle_entry) begin
                r_acc      <= '0;
                r_samp_cnt <= '0;
            end else if (w_sample) begin
                r_acc      <= w_acc_sum;
                r_samp_cnt <= w_samp_inc;
            end
            r_sar_reset    <= (w_state_nxt != S_CONV);
            r_busy         <= (w_state_nxt != S_IDLE);
            r_result_valid <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) begin
                r_result_chan <= r_chan_sel;
                r_result_data <= w_acc_sum[AVG_LOG2 +: 8];
            end
            if (w_timeout)      r_timeout_err <= 1'b1;
            else if (i_err_clr) r_timeout_err <= 1'b0;
        end
    end

    assign o_sar_reset    = r_sar_reset;
    assign o_chan_sel     = r_chan_sel;
    assign o_busy         = r_busy;
    assign o_result_valid = r_result_valid;
    assign o_result_chan  = r_result_chan;
    assign o_result_data  = r_result_data;
    assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Bench for sar_scan_sequencer: two instances (default averaging, and AVG_LOG2=0/SETTLE=1) driven by behavioural SAR models.
module tb_sar_scan_sequencer;
    localparam int NCH = 4, AVG_LOG2 = 2, SETTLE = 2, TIMEOUT = 31;
    localparam int B_SETTLE = 1, B_C = 5;

    logic clk = 1'b0;
    logic rst, scan_en, cont, err_clr;
    logic [3:0] chan_mask, b_mask;
    logic sar_ready = 1'b0, b_sar_ready = 1'b0;
    logic [7:0] sar_data = 8'h00, b_sar_data = 8'h00;
    logic sar_reset, busy, rv, terr, b_sar_reset, b_busy, b_rv, b_terr;
    logic [1:0] chan_sel, rchan, b_chan_sel, b_rchan;
    logic [7:0] rdata, b_rdata;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    sar_scan_sequencer #(.NCH(NCH), .AVG_LOG2(AVG_LOG2), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_scan_en(scan_en), .i_continuous(cont), .i_chan_mask(chan_mask),
        .i_err_clr(err_clr), .i_sar_ready(sar_ready), .i_sar_data(sar_data), .o_sar_reset(sar_reset),
        .o_chan_sel(chan_sel), .o_busy(busy), .o_result_valid(rv), .o_result_chan(rchan),
        .o_result_data(rdata), .o_timeout_err(terr));

    sar_scan_sequencer #(.NCH(NCH), .AVG_LOG2(0), .SETTLE(B_SETTLE), .TIMEOUT(TIMEOUT)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_scan_en(scan_en), .i_continuous(cont), .i_chan_mask(b_mask),
        .i_err_clr(err_clr), .i_sar_ready(b_sar_ready), .i_sar_data(b_sar_data), .o_sar_reset(b_sar_reset),
        .o_chan_sel(b_chan_sel), .o_busy(b_busy), .o_result_valid(b_rv), .o_result_chan(b_rchan),
        .o_result_data(b_rdata), .o_timeout_err(b_terr));

    // SAR core model: Ready sar_c cycles after reset release, data from a queue, dead channels never answer.
    int sar_c = 10, sar_cnt = 0, b_cnt = 0;
    logic [3:0] sar_dead = 4'b0000;
    logic [7:0] sar_q[$];
    always @(posedge clk) begin
        #1;
        if (sar_reset) begin
            sar_cnt = 0; sar_ready = 1'b0;
        end else if (!sar_ready) begin
            sar_cnt++;
            if (sar_cnt >= sar_c && !sar_dead[chan_sel]) begin
                sar_ready = 1'b1;
                if (sar_q.size() > 0) sar_data = sar_q.pop_front();
                else sar_data = 8'h00;
            end
        end
    end
    always @(posedge clk) begin
        #1;
        if (b_sar_reset) begin
            b_cnt = 0; b_sar_ready = 1'b0;
        end else if (!b_sar_ready) begin
            b_cnt++;
            if (b_cnt >= B_C) begin b_sar_ready = 1'b1; b_sar_data = 8'h37; end
        end
    end

    // Passive monitor, sampled on the falling edge.
    logic [1:0] rq_chan[$], b_rq_chan[$], exp_chan[$];
    logic [7:0] rq_data[$], b_rq_data[$], exp_data[$], stim_d[$];
    int b_rq_cyc[$];
    int cyc = 0, lows = 0, b_lows = 0, run_len = 0, last_run = 0, chg_viol = 0, busy_seen = 0, rv_double = 0;
    bit terr_seen = 0;
    logic prev_sr = 1'b1, prev_bsr = 1'b1, prev_rv = 1'b0;
    logic [1:0] prev_cs = 2'd0;
    always @(negedge clk) begin
        cyc++;
        if (rv) begin rq_chan.push_back(rchan); rq_data.push_back(rdata); end
        if (b_rv) begin b_rq_chan.push_back(b_rchan); b_rq_data.push_back(b_rdata); b_rq_cyc.push_back(cyc); end
        if (!sar_reset && prev_sr) lows++;
        if (!b_sar_reset && prev_bsr) b_lows++;
        if (!sar_reset) run_len++;
        else if (!prev_sr) begin last_run = run_len; run_len = 0; end
        if (!sar_reset && chan_sel != prev_cs) chg_viol++;
        if (busy) busy_seen++;
        if (terr) terr_seen = 1;
        if (rv && prev_rv) rv_double++;
        prev_sr = sar_reset; prev_bsr = b_sar_reset; prev_rv = rv; prev_cs = chan_sel;
    end

    task automatic clear_mon();
        rq_chan.delete(); rq_data.delete(); b_rq_chan.delete(); b_rq_data.delete(); b_rq_cyc.delete();
        lows = 0; b_lows = 0; run_len = 0; last_run = 0; chg_viol = 0; busy_seen = 0; rv_double = 0; terr_seen = 0;
    endtask

    // Reference: channels in ascending order, each consumes 2^AVG_LOG2 consecutive samples, result = floor(mean).
    function automatic void build_expect(input logic [3:0] m);
        int k, sum;
        k = 0;
        exp_chan.delete(); exp_data.delete();
        for (int ch = 0; ch < NCH; ch++) begin
            if (m[ch]) begin
                sum = 0;
                for (int s = 0; s < (1 << AVG_LOG2); s++) begin sum += int'(stim_d[k]); k++; end
                exp_chan.push_back(2'(ch));
                exp_data.push_back(8'(sum >> AVG_LOG2));
            end
        end
    endfunction

    task automatic gen_data(input int n);
        stim_d.delete();
        for (int i = 0; i < n; i++) stim_d.push_back(8'($urandom_range(0, 255)));
        sar_q = stim_d;
    endtask

    task automatic start_scan(input logic [3:0] a, input logic [3:0] b);
        @(posedge clk); #1;
        chan_mask = a; b_mask = b; scan_en = 1'b1;
    endtask

    // Waits for both instances to go idle and drops ScanEn before IDLE can restart.
    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (!busy && !b_busy) begin ok = 1; break; end
        end
        scan_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (sar_reset !== 1'b1) begin bad++; $display("FAIL reset_sar_reset got=%0b exp=1", sar_reset); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rv); end
        total++; if (chan_sel !== 2'd0) begin bad++; $display("FAIL reset_chan_sel got=%0d exp=0", chan_sel); end
        total++; if (rchan !== 2'd0 || rdata !== 8'h00) begin bad++; $display("FAIL reset_result got=ch%0d/%02h exp=ch0/00", rchan, rdata); end
        total++; if (terr !== 1'b0 || b_terr !== 1'b0) begin bad++; $display("FAIL reset_terr got=%0b/%0b exp=0/0", terr, b_terr); end
        total++; if (b_sar_reset !== 1'b1 || b_busy !== 1'b0 || b_chan_sel !== 2'd0) begin bad++; $display("FAIL reset_b got=%0b/%0b/%0d exp=1/0/0", b_sar_reset, b_busy, b_chan_sel); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_scan();
        int edges;
        bit ok;
        clear_mon(); sar_c = 10; sar_dead = 4'b0000; cont = 1'b0;
        stim_d = {8'h40, 8'h41, 8'h42, 8'h43, 8'h40, 8'h41, 8'h42, 8'h43};
        sar_q = stim_d;
        build_expect(4'b1010);
        start_scan(4'b1010, 4'b0000);
        @(posedge clk); #1; edges = 1;
        total++; if (busy !== 1'b1 || chan_sel !== 2'd1) begin bad++; $display("FAIL single_start got=busy%0b/ch%0d exp=busy1/ch1", busy, chan_sel); end
        while (sar_reset && edges < 20) begin @(posedge clk); #1; edges++; end
        total++; if (edges != 1 + SETTLE) begin bad++; $display("FAIL single_settle got=%0d exp=%0d", edges, 1 + SETTLE); end
        wait_idle(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_idle got=busy exp=idle"); end
        total++; if (rq_chan.size() != exp_chan.size()) begin bad++; $display("FAIL single_count got=%0d exp=%0d", rq_chan.size(), exp_chan.size()); end
        for (int i = 0; i < exp_chan.size() && i < rq_chan.size(); i++) begin
            total++;
            if (rq_chan[i] !== exp_chan[i] || rq_data[i] !== exp_data[i]) begin
                bad++; $display("FAIL single_res%0d got=ch%0d/%02h exp=ch%0d/%02h", i, rq_chan[i], rq_data[i], exp_chan[i], exp_data[i]);
            end
        end
        total++; if (lows != 8) begin bad++; $display("FAIL single_lows got=%0d exp=8", lows); end
        total++; if (chg_viol != 0 || rv_double != 0) begin bad++; $display("FAIL single_glitch got=%0d/%0d exp=0/0", chg_viol, rv_double); end
    endtask

    task automatic test_random_scan();
        logic [3:0] m;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            clear_mon();
            m = 4'($urandom_range(1, 15));
            sar_c = $urandom_range(1, 12);
            gen_data($countones(m) << AVG_LOG2);
            build_expect(m);
            start_scan(m, 4'b0000);
            repeat (2) @(posedge clk);
            wait_idle(4000, ok);
            total++; if (!ok || rq_chan.size() != exp_chan.size()) begin bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, rq_chan.size(), exp_chan.size()); end
            for (int i = 0; i < exp_chan.size() && i < rq_chan.size(); i++) begin
                total++;
                if (rq_chan[i] !== exp_chan[i] || rq_data[i] !== exp_data[i]) begin
                    bad++; $display("FAIL rand%0d_res%0d got=ch%0d/%02h exp=ch%0d/%02h", it, i, rq_chan[i], rq_data[i], exp_chan[i], exp_data[i]);
                end
            end
            total++; if (lows != ($countones(m) << AVG_LOG2) || chg_viol != 0) begin bad++; $display("FAIL rand%0d_lows got=%0d/%0d exp=%0d/0", it, lows, chg_viol, $countones(m) << AVG_LOG2); end
        end
    endtask

    task automatic run_until_results(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (rq_chan.size() >= n) begin ok = 1; break; end
        end
        scan_en = 1'b0;
    endtask

    task automatic test_continuous();
        bit ok, ok2;
        clear_mon(); sar_c = 4; cont = 1'b1;
        stim_d.delete();
        for (int i = 0; i < 40; i++) stim_d.push_back(8'hFF);
        sar_q = stim_d;
        start_scan(4'b0001, 4'b0000);
        run_until_results(3, ok);
        wait_idle(200, ok2);
        cont = 1'b0;
        total++; if (!ok || !ok2 || rq_chan.size() != 3) begin bad++; $display("FAIL cont_count got=%0d exp=3", rq_chan.size()); end
        for (int i = 0; i < rq_chan.size(); i++) begin
            total++;
            if (rq_chan[i] !== 2'd0 || rq_data[i] !== 8'hFF) begin bad++; $display("FAIL cont_res%0d got=ch%0d/%02h exp=ch0/ff", i, rq_chan[i], rq_data[i]); end
        end
    endtask

    task automatic test_mask_change();
        bit ok, ok2;
        clear_mon(); sar_c = $urandom_range(2, 8); cont = 1'b1;
        gen_data(16);
        build_expect(4'b1111);
        start_scan(4'b0011, 4'b0000);
        repeat (5) @(posedge clk);
        #1 chan_mask = 4'b1100;
        run_until_results(4, ok);
        wait_idle(200, ok2);
        cont = 1'b0;
        total++; if (!ok || !ok2 || rq_chan.size() != 4) begin bad++; $display("FAIL maskchg_count got=%0d exp=4", rq_chan.size()); end
        for (int i = 0; i < 4 && i < rq_chan.size(); i++) begin
            total++;
            if (rq_chan[i] !== exp_chan[i] || rq_data[i] !== exp_data[i]) begin
                bad++; $display("FAIL maskchg_res%0d got=ch%0d/%02h exp=ch%0d/%02h", i, rq_chan[i], rq_data[i], exp_chan[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_zero_mask();
        clear_mon();
        start_scan(4'b0000, 4'b0000);
        repeat (20) @(posedge clk);
        #1 scan_en = 1'b0;
        total++; if (busy_seen != 0) begin bad++; $display("FAIL zero_busy got=%0d exp=0", busy_seen); end
        total++; if (lows != 0 || sar_reset !== 1'b1) begin bad++; $display("FAIL zero_sar got=%0d/%0b exp=0/1", lows, sar_reset); end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_mon(); sar_c = 6; sar_dead = 4'b0100; err_clr = 1'b0;
        gen_data(4);
        build_expect(4'b0010);
        start_scan(4'b0110, 4'b0000);
        repeat (2) @(posedge clk);
        wait_idle(1000, ok);
        total++; if (!ok || rq_chan.size() != 1) begin bad++; $display("FAIL tmo_count got=%0d exp=1", rq_chan.size()); end
        if (rq_chan.size() > 0) begin
            total++;
            if (rq_chan[0] !== exp_chan[0] || rq_data[0] !== exp_data[0]) begin bad++; $display("FAIL tmo_res got=ch%0d/%02h exp=ch%0d/%02h", rq_chan[0], rq_data[0], exp_chan[0], exp_data[0]); end
        end
        total++; if (terr !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%0b exp=1", terr); end
        total++; if (last_run != TIMEOUT || lows != 5) begin bad++; $display("FAIL tmo_len got=%0d/%0d exp=%0d/5", last_run, lows, TIMEOUT); end
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        total++; if (terr !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%0b exp=0", terr); end
        clear_mon();
        gen_data(4);
        err_clr = 1'b1;
        start_scan(4'b0110, 4'b0000);
        repeat (2) @(posedge clk);
        wait_idle(1000, ok);
        total++; if (!terr_seen) begin bad++; $display("FAIL tmo_setwins got=0 exp=1"); end
        total++; if (terr !== 1'b0) begin bad++; $display("FAIL tmo_heldclr got=%0b exp=0", terr); end
        err_clr = 1'b0; sar_dead = 4'b0000;
    endtask

    task automatic test_reset_mid_conv();
        bit ok;
        clear_mon(); sar_c = 10;
        gen_data(8);
        start_scan(4'b0010, 4'b0000);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (lows == 2 && !sar_reset) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL rst_reach got=lows%0d exp=lows2", lows); end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++; if (sar_reset !== 1'b1 || busy !== 1'b0 || rv !== 1'b0) begin bad++; $display("FAIL rst_ctrl got=%0b/%0b/%0b exp=1/0/0", sar_reset, busy, rv); end
        total++; if (chan_sel !== 2'd0 || rchan !== 2'd0 || rdata !== 8'h00) begin bad++; $display("FAIL rst_data got=%0d/%0d/%02h exp=0/0/00", chan_sel, rchan, rdata); end
        scan_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        total++; if (rq_chan.size() != 0) begin bad++; $display("FAIL rst_noresult got=%0d exp=0", rq_chan.size()); end
        clear_mon();
        gen_data(4);
        build_expect(4'b0100);
        start_scan(4'b0100, 4'b0000);
        repeat (2) @(posedge clk);
        wait_idle(1000, ok);
        total++; if (!ok || rq_chan.size() != 1) begin bad++; $display("FAIL rst_rescan_count got=%0d exp=1", rq_chan.size()); end
        if (rq_chan.size() > 0) begin
            total++;
            if (rq_chan[0] !== exp_chan[0] || rq_data[0] !== exp_data[0]) begin bad++; $display("FAIL rst_rescan got=ch%0d/%02h exp=ch%0d/%02h", rq_chan[0], rq_data[0], exp_chan[0], exp_data[0]); end
        end
    endtask

    task automatic test_avg0();
        bit ok;
        clear_mon(); cont = 1'b0;
        start_scan(4'b0000, 4'b0011);
        repeat (2) @(posedge clk);
        wait_idle(500, ok);
        b_mask = 4'b0000;
        total++; if (!ok || b_rq_chan.size() != 2 || rq_chan.size() != 0) begin bad++; $display("FAIL avg0_count got=%0d/%0d exp=2/0", b_rq_chan.size(), rq_chan.size()); end
        for (int i = 0; i < b_rq_chan.size(); i++) begin
            total++;
            if (b_rq_chan[i] !== 2'(i) || b_rq_data[i] !== 8'h37) begin bad++; $display("FAIL avg0_res%0d got=ch%0d/%02h exp=ch%0d/37", i, b_rq_chan[i], b_rq_data[i], i); end
        end
        total++; if (b_lows != 2) begin bad++; $display("FAIL avg0_lows got=%0d exp=2", b_lows); end
        if (b_rq_cyc.size() == 2) begin
            total++;
            if (b_rq_cyc[1] - b_rq_cyc[0] != B_SETTLE + (B_C + 1) + 2 - 1) begin
                bad++; $display("FAIL avg0_latency got=%0d exp=%0d", b_rq_cyc[1] - b_rq_cyc[0], B_SETTLE + (B_C + 1) + 2 - 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; scan_en = 1'b0; cont = 1'b0; err_clr = 1'b0; chan_mask = 4'b0000; b_mask = 4'b0000;
        test_reset();
        test_single_scan();
        test_random_scan();
        test_continuous();
        test_mask_change();
        test_zero_mask();
        test_timeout();
        test_reset_mid_conv();
        test_avg0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
